// File: rtl/sid_acc_sched.sv
`timescale 1ns/1ps
// Time-multiplexed 24-bit phase accumulator and noise LFSR sequencer for all SID voices.
// Optional overrun counter (ovr_cnt/ovr_clr) is built when SID_ACC_SCHED_OVR_EN is defined.
module sid_acc_sched #(
    parameter int NVOICES = 3,
    parameter int VW      = 2
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               tick,
    input  logic               cfg_we,
    input  logic [VW-1:0]      cfg_voice,
    input  logic [15:0]        cfg_freq,
    input  logic               cfg_test,
    input  logic               cfg_sync,
    input  logic [VW-1:0]      rd_voice,
    output logic [23:0]        rd_acc,
    output logic [22:0]        rd_lfsr,
    output logic [NVOICES-1:0] sync_out,
    output logic               busy,
    output logic               done
`ifdef SID_ACC_SCHED_OVR_EN
    ,
    output logic [7:0]         ovr_cnt,
    input  logic               ovr_clr
`endif
);

    localparam logic [VW-1:0] LAST      = VW'(NVOICES - 1);
    localparam logic [VW:0]   NV_W      = (VW+1)'(NVOICES);
    localparam logic [22:0]   LFSR_INIT = 23'h7FFFFF;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [VW-1:0]       r_idx;
    logic [VW-1:0]       w_idx_nx;
    logic                w_last;

    logic [23:0]         r_acc     [NVOICES];
    logic [22:0]         r_lfsr    [NVOICES];
    logic [15:0]         r_freq    [NVOICES];
    logic [NVOICES-1:0]  r_test;
    logic [NVOICES-1:0]  r_sync_en;
    logic [NVOICES-1:0]  r_shadow;
    logic [NVOICES-1:0]  r_sync_out;
    logic [23:0]         r_rd_acc;
    logic [22:0]         r_rd_lfsr;
    logic                r_done;

    logic [VW-1:0]       w_prev;
    logic [23:0]         w_sum;
    logic [23:0]         w_new_acc;
    logic [22:0]         w_new_lfsr;
    logic                w_rise;
    logic [NVOICES-1:0]  w_shadow_nx;
    logic                w_cfg_ok;
    logic                w_rd_ok;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    // A tick arriving while in RUN is not a transition; it is only counted as an overrun.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tick) begin
                    w_state_nx = S_RUN;
                    w_idx_nx   = '0;
                end
            end
            S_RUN: begin
                if (r_idx == LAST) begin
                    w_state_nx = S_IDLE;
                    w_last     = 1'b1;
                end else begin
                    w_idx_nx = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = '0;
            end
        endcase
    end

    // Sync reads r_sync_out (previous pass) for every voice, so voice 0 sees the last voice's flag too.
    always_comb begin
        w_prev     = (r_idx == '0) ? LAST : r_idx - 1'b1;
        w_sum      = r_acc[r_idx] + {8'h00, r_freq[r_idx]};
        w_new_acc  = w_sum;
        w_new_lfsr = r_lfsr[r_idx];
        if (r_test[r_idx]) begin
            w_new_acc  = '0;
            w_new_lfsr = LFSR_INIT;
        end else begin
            if (r_sync_en[r_idx] && r_sync_out[w_prev]) begin
                w_new_acc = '0;
            end
            if (!r_acc[r_idx][19] && w_new_acc[19]) begin
                w_new_lfsr = {r_lfsr[r_idx][21:0], r_lfsr[r_idx][17] ^ r_lfsr[r_idx][22]};
            end
        end
        w_rise             = !r_acc[r_idx][23] && w_new_acc[23];
        w_shadow_nx        = r_shadow;
        w_shadow_nx[r_idx] = w_rise;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NVOICES; i++) begin
                r_acc[i]  <= '0;
                r_lfsr[i] <= LFSR_INIT;
            end
            r_shadow   <= '0;
            r_sync_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (r_state == S_RUN) begin
                r_acc[r_idx]  <= w_new_acc;
                r_lfsr[r_idx] <= w_new_lfsr;
                r_shadow      <= w_shadow_nx;
                if (w_last) begin
                    r_sync_out <= w_shadow_nx;
                end
            end
        end
    end

    assign w_cfg_ok = {1'b0, cfg_voice} < NV_W;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NVOICES; i++) begin
                r_freq[i] <= '0;
            end
            r_test    <= '0;
            r_sync_en <= '0;
        end else if (cfg_we && w_cfg_ok) begin
            r_freq[cfg_voice]    <= cfg_freq;
            r_test[cfg_voice]    <= cfg_test;
            r_sync_en[cfg_voice] <= cfg_sync;
        end
    end

    assign w_rd_ok = {1'b0, rd_voice} < NV_W;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rd_acc  <= '0;
            r_rd_lfsr <= '0;
        end else begin
            r_rd_acc  <= w_rd_ok ? r_acc[rd_voice]  : 24'h000000;
            r_rd_lfsr <= w_rd_ok ? r_lfsr[rd_voice] : 23'h000000;
        end
    end

`ifdef SID_ACC_SCHED_OVR_EN
    logic [7:0] r_ovr_cnt;
    logic       w_ovr;

    assign w_ovr = tick && (r_state == S_RUN);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_ovr_cnt <= '0;
        end else if (ovr_clr) begin
            r_ovr_cnt <= '0;
        end else if (w_ovr && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'h01;
        end
    end

    assign ovr_cnt = r_ovr_cnt;
`endif

    assign rd_acc   = r_rd_acc;
    assign rd_lfsr  = r_rd_lfsr;
    assign sync_out = r_sync_out;
    assign busy     = (r_state == S_RUN);
    assign done     = r_done;

endmodule

// File: tb/tb_sid_acc_sched.sv
`timescale 1ns/1ps
// Bench for sid_acc_sched: directed vector table, hand-written corner sequences and
// randomized config/tick traffic checked against a pass-level reference model.
module tb_sid_acc_sched;

    localparam int NV = 3;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          tick = 1'b0;
    logic          cfg_we = 1'b0;
    logic [VW-1:0] cfg_voice = '0;
    logic [15:0]   cfg_freq = '0;
    logic          cfg_test = 1'b0;
    logic          cfg_sync = 1'b0;
    logic [VW-1:0] rd_voice = '0;
    logic [23:0]   rd_acc;
    logic [22:0]   rd_lfsr;
    logic [NV-1:0] sync_out;
    logic          busy;
    logic          done;
`ifdef SID_ACC_SCHED_OVR_EN
    logic [7:0]    ovr_cnt;
    logic          ovr_clr = 1'b0;
`endif

    sid_acc_sched #(.NVOICES(NV), .VW(VW)) dut (
        .clk(clk), .n_reset(n_reset), .tick(tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_freq(cfg_freq),
        .cfg_test(cfg_test), .cfg_sync(cfg_sync),
        .rd_voice(rd_voice), .rd_acc(rd_acc), .rd_lfsr(rd_lfsr),
        .sync_out(sync_out), .busy(busy), .done(done)
`ifdef SID_ACC_SCHED_OVR_EN
        , .ovr_cnt(ovr_cnt), .ovr_clr(ovr_clr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: whole-pass view of the voice bank.
    logic [23:0] m_acc  [NV];
    logic [22:0] m_lfsr [NV];
    logic [15:0] m_freq [NV];
    logic        m_test [NV];
    logic        m_sync [NV];
    logic [NV-1:0] m_sync_out;

    typedef struct {
        int          v;
        logic [15:0] f;
        int          n;
        logic [23:0] ea;
        logic [22:0] el;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_acc[i] = 24'h0; m_lfsr[i] = 23'h7FFFFF; m_freq[i] = 16'h0;
            m_test[i] = 1'b0; m_sync[i] = 1'b0;
        end
        m_sync_out = '0;
    endfunction

    function automatic void model_cfg(input int v, input logic [15:0] f, input logic t, input logic s);
        if (v < NV) begin
            m_freq[v] = f; m_test[v] = t; m_sync[v] = s;
        end
    endfunction

    function automatic void model_pass();
        logic [NV-1:0] rises;
        logic [23:0]   nxt;
        int            p;
        rises = '0;
        for (int i = 0; i < NV; i++) begin
            p   = (i + NV - 1) % NV;
            nxt = 24'((32'(m_acc[i]) + 32'(m_freq[i])) % 32'h0100_0000);
            if (m_test[i]) begin
                nxt = 24'h0;
                m_lfsr[i] = 23'h7FFFFF;
            end else begin
                if (m_sync[i] && m_sync_out[p]) nxt = 24'h0;
                if (!m_acc[i][19] && nxt[19])
                    m_lfsr[i] = {m_lfsr[i][21:0], m_lfsr[i][17] ^ m_lfsr[i][22]};
            end
            rises[i] = !m_acc[i][23] && nxt[23];
            m_acc[i] = nxt;
        end
        m_sync_out = rises;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0; tick = 1'b0; cfg_we = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_sync_out", 32'(sync_out), 32'h0);
        chk("rst_rd_acc", 32'(rd_acc), 32'h0);
        chk("rst_rd_lfsr", 32'(rd_lfsr), 32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        model_reset();
    endtask

    task automatic cfg_write(input int v, input logic [15:0] f, input logic t, input logic s);
        @(negedge clk);
        cfg_we = 1'b1; cfg_voice = VW'(v); cfg_freq = f; cfg_test = t; cfg_sync = s;
        @(negedge clk);
        cfg_we = 1'b0;
        model_cfg(v, f, t, s);
    endtask

    // Called at a negedge with the engine idle; returns at the negedge where done is high.
    task automatic do_tick(output int lat);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {31'b0, done}, 32'h1);
        model_pass();
    endtask

    task automatic run_ticks(input int n);
        int lat;
        for (int k = 0; k < n; k++) do_tick(lat);
    endtask

    task automatic check_voice(input int v, input logic [23:0] ea, input logic [22:0] el, input string name);
        rd_voice = VW'(v);
        @(negedge clk);
        chk({name, "_acc"}, 32'(rd_acc), 32'(ea));
        chk({name, "_lfsr"}, 32'(rd_lfsr), 32'(el));
    endtask

    task automatic check_model(input string name);
        for (int v = 0; v < NV; v++) check_voice(v, m_acc[v], m_lfsr[v], name);
        chk({name, "_sync_out"}, 32'(sync_out), 32'(m_sync_out));
    endtask

    initial begin
        int lat;
        int dcnt;

        tbl[0] = '{v: 0, f: 16'h1000, n: 16,  ea: 24'h010000, el: 23'h7FFFFF};
        tbl[1] = '{v: 0, f: 16'h8000, n: 16,  ea: 24'h080000, el: 23'h7FFFFE};
        tbl[2] = '{v: 1, f: 16'h0001, n: 3,   ea: 24'h000003, el: 23'h7FFFFF};
        tbl[3] = '{v: 2, f: 16'hFFFF, n: 2,   ea: 24'h01FFFE, el: 23'h7FFFFF};
        tbl[4] = '{v: 1, f: 16'h8000, n: 512, ea: 24'h000000, el: 23'h7F0000};

        // Reset state of every voice and the out-of-range read.
        do_reset();
        for (int v = 0; v < NV; v++) check_voice(v, 24'h0, 23'h7FFFFF, "reset_voice");
        check_voice(3, 24'h0, 23'h0, "rd_out_of_range");
        chk("reset_busy_idle", {31'b0, busy}, 32'h0);

        // First pass latency and busy flag.
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("busy_in_run", {31'b0, busy}, 32'h1);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("done_latency", 32'(lat), 32'(NV + 1));
        @(negedge clk);
        chk("done_one_clk", {31'b0, done}, 32'h0);

        // Directed table.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            cfg_write(tbl[t].v, tbl[t].f, 1'b0, 1'b0);
            @(negedge clk);
            run_ticks(tbl[t].n);
            check_voice(tbl[t].v, tbl[t].ea, tbl[t].el, $sformatf("tbl%0d", t));
            check_voice((tbl[t].v + 1) % NV, 24'h0, 23'h7FFFFF, $sformatf("tbl%0d_other", t));
        end

        // Hard sync: voice 2 rises at pass 256, voice 0 clears in pass 257.
        do_reset();
        cfg_write(2, 16'h8000, 1'b0, 1'b0);
        cfg_write(0, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        run_ticks(256);
        chk("sync_p256_flags", 32'(sync_out), 32'h4);
        check_voice(0, 24'h000100, 23'h7FFFFF, "sync_p256_v0");
        run_ticks(1);
        check_voice(0, 24'h000000, 23'h7FFFFF, "sync_p257_v0");
        chk("sync_p257_flags", 32'(sync_out), 32'h0);
        run_ticks(1);
        check_voice(0, 24'h000001, 23'h7FFFFF, "sync_p258_v0");

        // Test bit overrides a pending sync, then counting resumes from zero.
        do_reset();
        cfg_write(0, 16'h8000, 1'b0, 1'b0);
        cfg_write(1, 16'h0100, 1'b0, 1'b1);
        @(negedge clk);
        run_ticks(255);
        check_voice(1, 24'h00FF00, 23'h7FFFFF, "test_pre");
        cfg_write(1, 16'h0100, 1'b1, 1'b1);
        @(negedge clk);
        run_ticks(1);
        chk("test_sync_flag", 32'(sync_out), 32'h1);
        run_ticks(1);
        check_voice(1, 24'h000000, 23'h7FFFFF, "test_hold");
        cfg_write(1, 16'h0100, 1'b0, 1'b1);
        @(negedge clk);
        run_ticks(1);
        check_voice(1, 24'h000100, 23'h7FFFFF, "test_resume");
        check_model("test_model");

        // Config writes during a pass: same-clk voice keeps old value, later voice takes new.
        do_reset();
        cfg_write(0, 16'h0010, 1'b0, 1'b0);
        cfg_write(2, 16'h0010, 1'b0, 1'b0);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cfg_we = 1'b1; cfg_voice = 2'd0; cfg_freq = 16'h0020; cfg_test = 1'b0; cfg_sync = 1'b0;
        @(negedge clk);
        cfg_voice = 2'd2; cfg_freq = 16'h0030;
        @(negedge clk);
        cfg_we = 1'b0;
        lat = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("midpass_done", {31'b0, done}, 32'h1);
        check_voice(0, 24'h000010, 23'h7FFFFF, "midpass_v0");
        check_voice(2, 24'h000030, 23'h7FFFFF, "midpass_v2");
        model_cfg(2, 16'h0030, 1'b0, 1'b0);
        model_pass();
        model_cfg(0, 16'h0020, 1'b0, 1'b0);
        @(negedge clk);
        run_ticks(1);
        check_voice(0, 24'h000030, 23'h7FFFFF, "midpass_next_v0");
        cfg_write(3, 16'h1234, 1'b1, 1'b1);
        @(negedge clk);
        run_ticks(1);
        check_model("dropped_cfg");

        // Tick while busy is ignored.
        do_reset();
        cfg_write(0, 16'h0005, 1'b0, 1'b0);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("overrun_done_count", 32'(dcnt), 32'h1);
        check_voice(0, 24'h000005, 23'h7FFFFF, "overrun_v0");
`ifdef SID_ACC_SCHED_OVR_EN
        chk("ovr_cnt_one", 32'(ovr_cnt), 32'h1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_cnt_clr", 32'(ovr_cnt), 32'h0);
`endif

        // Reset in the middle of a pass aborts it.
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        model_reset();
        check_model("abort");

        // Randomized traffic against the model.
        do_reset();
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                int          v;
                logic [15:0] f;
                v = $urandom_range(0, 3);
                f = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hC000, 16'hFFFF)) : 16'($urandom);
                cfg_write(v, f, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            run_ticks($urandom_range(1, 40));
            check_model($sformatf("rand%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
